// File: rtl/sfr_irq_bank.sv
// Interrupt enable/flag register bank: up to 16 channels with edge or level sources.
// The lowest-numbered pending, enabled channel is presented as a registered request/ID pair.
module sfr_irq_bank #(
   parameter int          NCH       = 8,
   parameter logic [8:0]  BASE_ADDR = 9'h000,
   parameter logic [15:0] EDGE_MASK = 16'h0000,
   parameter bit          W1C       = 1'b0
) (
   input  logic             mclk,
   input  logic             puc_n,
   input  logic [7:0]       per_addr,
   input  logic [15:0]      per_din,
   input  logic             per_en,
   input  logic [1:0]       per_wen,
   input  logic [NCH-1:0]   irq_src,
   input  logic             irq_acc,
   output logic [15:0]      per_dout,
   output logic             irq_req,
   output logic [3:0]       irq_id,
   output logic [NCH-1:0]   irq_pend
);

   localparam logic [7:0]  IE_ADDR  = BASE_ADDR[8:1];
   localparam logic [7:0]  IFG_ADDR = IE_ADDR + 8'd1;
   localparam logic [15:0] IMPL     = 16'((32'd1 << NCH) - 32'd1);

   logic [15:0] ie_q, ie_d;
   logic [15:0] ifg_q, ifg_d;
   logic [15:0] srcPrev_q;
   logic        irqReq_q, irqReq_d;
   logic [3:0]  irqId_q, irqId_d;

   logic [15:0] srcExt;
   logic [15:0] setEv;
   logic [15:0] laneMask;
   logic [15:0] pend;
   logic [3:0]  lowId;
   logic        wrEn, rdEn, ieHit, ifgHit, accept;

   always_comb begin
      srcExt = '0;
      srcExt[NCH-1:0] = irq_src;
   end

   assign wrEn     = per_en & (|per_wen);
   assign rdEn     = per_en & ~(|per_wen);
   assign ieHit    = (per_addr == IE_ADDR);
   assign ifgHit   = (per_addr == IFG_ADDR);
   assign laneMask = {{8{per_wen[1]}}, {8{per_wen[0]}}} & IMPL;
   assign setEv    = ((EDGE_MASK & srcExt & ~srcPrev_q) | (~EDGE_MASK & srcExt)) & IMPL;
   assign pend     = ifg_q & ie_q;
   assign accept   = irq_acc & irqReq_q;

   // Later assignments take priority: software write, then acceptance clear, then set event.
   always_comb begin
      ie_d  = ie_q;
      ifg_d = ifg_q;
      if (wrEn && ieHit) begin
         ie_d = (ie_q & ~laneMask) | (per_din & laneMask);
      end
      if (wrEn && ifgHit) begin
         if (W1C) begin
            ifg_d = ifg_q & ~(per_din & laneMask);
         end else begin
            ifg_d = (ifg_q & ~laneMask) | (per_din & laneMask);
         end
      end
      if (accept) begin
         ifg_d[irqId_q] = 1'b0;
      end
      ifg_d = (ifg_d | setEv) & IMPL;
      ie_d  = ie_d & IMPL;
   end

   always_comb begin
      lowId = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pend[i]) begin
            lowId = 4'(i);
         end
      end
   end

   // An accepted request forces a one-cycle bubble so the cleared flag is seen before re-arbitration.
   always_comb begin
      irqReq_d = |pend;
      irqId_d  = lowId;
      if (accept) begin
         irqReq_d = 1'b0;
         irqId_d  = irqId_q;
      end
   end

   always_ff @(posedge mclk) begin
      srcPrev_q <= srcExt;
      if (!puc_n) begin
         ie_q     <= '0;
         ifg_q    <= '0;
         irqReq_q <= 1'b0;
         irqId_q  <= 4'd0;
      end else begin
         ie_q     <= ie_d;
         ifg_q    <= ifg_d;
         irqReq_q <= irqReq_d;
         irqId_q  <= irqId_d;
      end
   end

   always_comb begin
      per_dout = 16'h0000;
      if (rdEn && ieHit) begin
         per_dout = ie_q;
      end else if (rdEn && ifgHit) begin
         per_dout = ifg_q;
      end
   end

   assign irq_req  = irqReq_q;
   assign irq_id   = irqId_q;
   assign irq_pend = pend[NCH-1:0];

endmodule

// File: tb/tb_sfr_irq_bank.sv
// Scoreboard bench for sfr_irq_bank: two configurations share one bus, a channel-level
// reference model predicts each cycle's outputs and a monitor compares them at negedge.
module tb_sfr_irq_bank;

   typedef struct packed {
      logic [15:0] dout0;
      logic [15:0] dout1;
      logic        req0;
      logic        req1;
      logic [3:0]  id0;
      logic [3:0]  id1;
      logic [15:0] pend0;
      logic [15:0] pend1;
   } exp_t;

   logic        mclk = 1'b0;
   logic        puc_n;
   logic [7:0]  per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_wen;
   logic [15:0] irqSrc;
   logic [1:0]  irqAcc;

   logic [15:0] dout0, dout1;
   logic        req0, req1;
   logic [3:0]  id0, id1;
   logic [7:0]  pend0;
   logic [15:0] pend1;

   exp_t sbQ[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model state, one entry per instance
   int          nch[2]    = '{8, 16};
   logic [15:0] edgeM[2]  = '{16'h00FE, 16'hF0F0};
   bit          w1c[2]    = '{1'b0, 1'b1};
   logic [7:0]  ieAddr[2] = '{8'd0, 8'd8};
   logic [15:0] mIe[2], mIfg[2], mPrev[2];
   logic        mReq[2];
   logic [3:0]  mId[2];
   bit          modelValid = 1'b0;

   always #5 mclk = ~mclk;

   sfr_irq_bank #(.NCH(8), .BASE_ADDR(9'h000), .EDGE_MASK(16'h00FE), .W1C(1'b0)) dut0 (
      .mclk(mclk), .puc_n(puc_n), .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
      .per_wen(per_wen), .irq_src(irqSrc[7:0]), .irq_acc(irqAcc[0]), .per_dout(dout0),
      .irq_req(req0), .irq_id(id0), .irq_pend(pend0));

   sfr_irq_bank #(.NCH(16), .BASE_ADDR(9'h010), .EDGE_MASK(16'hF0F0), .W1C(1'b1)) dut1 (
      .mclk(mclk), .puc_n(puc_n), .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
      .per_wen(per_wen), .irq_src(irqSrc), .irq_acc(irqAcc[1]), .per_dout(dout1),
      .irq_req(req1), .irq_id(id1), .irq_pend(pend1));

   function automatic logic [15:0] expDout(input int k, input logic [7:0] a, input logic en,
                                           input logic [1:0] wen);
      if (!en || wen != 2'b00) return 16'h0000;
      if (a == ieAddr[k]) return mIe[k];
      if (a == ieAddr[k] + 8'd1) return mIfg[k];
      return 16'h0000;
   endfunction

   // Advances the model across one rising edge, following the per-channel flag rules.
   task automatic modelStep(input logic rstN, input logic [7:0] a, input logic [15:0] d,
                            input logic en, input logic [1:0] wen, input logic [15:0] src,
                            input logic [1:0] acc);
      logic [15:0] nIe, nIfg;
      logic        accepted, lane, wr, ev;
      int          low;
      for (int k = 0; k < 2; k++) begin
         if (!rstN) begin
            mIe[k] = '0; mIfg[k] = '0; mReq[k] = 1'b0; mId[k] = 4'd0;
         end else begin
            accepted = acc[k] && mReq[k];
            nIe  = mIe[k];
            nIfg = mIfg[k];
            for (int i = 0; i < nch[k]; i++) begin
               lane = (i < 8) ? wen[0] : wen[1];
               wr   = en && lane;
               ev   = edgeM[k][i] ? (src[i] && !mPrev[k][i]) : src[i];
               if (wr && a == ieAddr[k]) nIe[i] = d[i];
               if (ev) nIfg[i] = 1'b1;
               else if (accepted && mId[k] == i) nIfg[i] = 1'b0;
               else if (wr && a == ieAddr[k] + 8'd1) nIfg[i] = w1c[k] ? (d[i] ? 1'b0 : mIfg[k][i]) : d[i];
            end
            if (accepted) begin
               mReq[k] = 1'b0;
            end else begin
               low = -1;
               for (int i = nch[k] - 1; i >= 0; i--) begin
                  if (mIe[k][i] && mIfg[k][i]) low = i;
               end
               mReq[k] = (low >= 0);
               mId[k]  = (low >= 0) ? 4'(low) : 4'd0;
            end
            mIe[k]  = nIe;
            mIfg[k] = nIfg;
         end
         mPrev[k] = src;
      end
   endtask

   // Drives one cycle of inputs, queues that cycle's expected outputs, then steps the model.
   task automatic applyStimulus(input logic rstN, input logic [7:0] a, input logic [15:0] d,
                                input logic en, input logic [1:0] wen, input logic [15:0] src,
                                input logic [1:0] acc);
      exp_t e;
      @(posedge mclk);
      #1;
      puc_n = rstN; per_addr = a; per_din = d; per_en = en; per_wen = wen;
      irqSrc = src; irqAcc = acc;
      if (modelValid) begin
         e.dout0 = expDout(0, a, en, wen);
         e.dout1 = expDout(1, a, en, wen);
         e.req0  = mReq[0];
         e.req1  = mReq[1];
         e.id0   = mId[0];
         e.id1   = mId[1];
         e.pend0 = mIe[0] & mIfg[0];
         e.pend1 = mIe[1] & mIfg[1];
         sbQ.push_back(e);
      end
      modelStep(rstN, a, d, en, wen, src, acc);
      if (!rstN) modelValid = 1'b1;
   endtask

   task automatic cyc(input logic [7:0] a, input logic [15:0] d, input logic en,
                      input logic [1:0] wen, input logic [15:0] src, input logic [1:0] acc);
      applyStimulus(1'b1, a, d, en, wen, src, acc);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs against the queued expectation for the current cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge mclk);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("dout0", dout0, e.dout0);
            checkOutput("dout1", dout1, e.dout1);
            checkOutput("req0", {15'd0, req0}, {15'd0, e.req0});
            checkOutput("req1", {15'd0, req1}, {15'd0, e.req1});
            checkOutput("id0", {12'd0, id0}, {12'd0, e.id0});
            checkOutput("id1", {12'd0, id1}, {12'd0, e.id1});
            checkOutput("pend0", {8'd0, pend0}, e.pend0);
            checkOutput("pend1", pend1, e.pend1);
         end
      end
   end

   initial begin
      logic [15:0] src;
      logic [7:0]  a;
      logic [1:0]  wen;
      puc_n = 1'b0; per_addr = '0; per_din = '0; per_en = 1'b0; per_wen = '0;
      irqSrc = 16'hFFFF; irqAcc = '0;

      // Reset with all sources high, then readback of both instances
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 2'b00, 16'hFFFF, 2'b00);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 2'b00, 16'hFFFF, 2'b00);
      cyc(8'd0, 16'h0, 1'b1, 2'b00, 16'hFFFF, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'hFFFF, 2'b00);
      cyc(8'd8, 16'h0, 1'b1, 2'b00, 16'hFFFF, 2'b00);
      cyc(8'd9, 16'h0, 1'b1, 2'b00, 16'hFFFF, 2'b00);
      cyc(8'd0, 16'hFFFF, 1'b1, 2'b11, 16'hFFFF, 2'b00);
      cyc(8'd0, 16'h0, 1'b1, 2'b00, 16'hFFFF, 2'b00);

      // Edge latency, arbitration and acceptance bubble on instance 0
      cyc(8'd1, 16'h0000, 1'b1, 2'b11, 16'h0000, 2'b00);
      cyc(8'd0, 16'h000C, 1'b1, 2'b11, 16'h0000, 2'b00);
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h000C, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0000, 2'b11);
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0000, 2'b00);
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0000, 2'b11);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);

      // Set event on the accepted channel in the acceptance cycle
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0004, 2'b00);
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0000, 2'b00);
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0004, 2'b01);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0000, 2'b01);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);

      // Write-load versus write-one-to-clear
      cyc(8'd1, 16'h0005, 1'b1, 2'b11, 16'h0000, 2'b00);
      cyc(8'd1, 16'h0004, 1'b1, 2'b01, 16'h0000, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd9, 16'h0, 1'b1, 2'b00, 16'h0005, 2'b00);
      cyc(8'd9, 16'h0004, 1'b1, 2'b01, 16'h0000, 2'b00);
      cyc(8'd9, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);

      // Byte lanes on the 16-channel instance
      cyc(8'd8, 16'hA55A, 1'b1, 2'b10, 16'h0000, 2'b00);
      cyc(8'd8, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd8, 16'h00FF, 1'b1, 2'b01, 16'h0000, 2'b00);
      cyc(8'd8, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd8, 16'h0, 1'b0, 2'b00, 16'h0000, 2'b00);

      // Level source defeats software clear until it drops
      cyc(8'd0, 16'h0001, 1'b1, 2'b11, 16'h0001, 2'b00);
      cyc(8'd1, 16'h0000, 1'b1, 2'b11, 16'h0001, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0001, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);
      cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b11);
      for (int i = 0; i < 4; i++) cyc(8'd1, 16'h0, 1'b1, 2'b00, 16'h0000, 2'b00);

      // Randomised traffic with slowly toggling sources and occasional reset
      src = 16'h0000;
      for (int n = 0; n < 3000; n++) begin
         src = src ^ 16'($urandom & $urandom & $urandom);
         case ($urandom_range(0, 4))
            0: a = 8'd0;
            1: a = 8'd1;
            2: a = 8'd8;
            3: a = 8'd9;
            default: a = 8'($urandom_range(0, 255));
         endcase
         wen = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         applyStimulus(($urandom_range(0, 199) != 0), a, 16'($urandom),
                       ($urandom_range(0, 1) == 1), wen, src,
                       {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)});
      end

      cyc(8'd0, 16'h0, 1'b0, 2'b00, 16'h0000, 2'b00);
      @(posedge mclk);
      @(posedge mclk);
      checks++;
      if (sbQ.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sbQ.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
